// File: rtl/gemm_cmd_regs_pkg.sv
// Shared types and register map for the GEMM tile-command register file.
package gemm_cmd_regs_pkg;

  localparam int unsigned CMD_ADDR_W   = 32;
  localparam int unsigned CMD_STRIDE_W = 32;
  localparam int unsigned SIZE_W       = 5;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0]   tile_a_addr;
    logic [CMD_ADDR_W-1:0]   tile_b_addr;
    logic [CMD_ADDR_W-1:0]   tile_c_addr;
    logic [CMD_STRIDE_W-1:0] a_stride;
    logic [CMD_STRIDE_W-1:0] b_stride;
    logic                    first;
    logic                    last;
    logic [SIZE_W-1:0]       msize;
    logic [SIZE_W-1:0]       ksize;
    logic [SIZE_W-1:0]       nsize;
  } gemm_cmd_t;

  localparam logic [4:0] REG_A_ADDR   = 5'h00;
  localparam logic [4:0] REG_B_ADDR   = 5'h04;
  localparam logic [4:0] REG_C_ADDR   = 5'h08;
  localparam logic [4:0] REG_A_STRIDE = 5'h0C;
  localparam logic [4:0] REG_B_STRIDE = 5'h10;
  localparam logic [4:0] REG_CONTROL  = 5'h14;
  localparam logic [4:0] REG_DIM      = 5'h18;
  localparam logic [4:0] REG_STATUS   = 5'h1C;

  localparam int unsigned DIM_M_LSB = 0;
  localparam int unsigned DIM_K_LSB = 5;
  localparam int unsigned DIM_N_LSB = 10;

  // Extract one size field from a GEMM_DIM write word.
  function automatic logic [SIZE_W-1:0] dim_field(input logic [31:0] wr, input int unsigned lsb);
    return wr[lsb +: SIZE_W];
  endfunction

endpackage

// File: rtl/gemm_cmd_regs_fifo.sv
// Generic synchronous FIFO with full/empty/count; head entry read from registered storage.
module gemm_cmd_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears storage so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gemm_cmd_regs.sv
// Bus-mapped tile-configuration registers; a GEMM_DIM write commits the shadows as one command.
module gemm_cmd_regs
  import gemm_cmd_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int unsigned ADDR_W    = CMD_ADDR_W,
  parameter int unsigned STRIDE_W  = CMD_STRIDE_W,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        system_bus_en,
  input  logic        system_bus_rdwr,
  input  logic [31:0] system_bus_addr,
  input  logic [31:0] system_bus_wr_data,
  output logic [31:0] system_bus_rd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output gemm_cmd_t   cmd_data,
  input  logic        engine_busy
);

  logic [1:0]            rst_sync_q, rst_sync_d;
  logic                  rst_n;
  logic [ADDR_W-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [STRIDE_W-1:0]   a_stride_q, a_stride_d, b_stride_q, b_stride_d;
  logic                  first_q, first_d, last_q, last_d;
  logic                  ovf_q, ovf_d, derr_q, derr_d;
  logic                  hit, wr_en, rd_en, push, pop, size_ok, full, empty, done;
  logic [4:0]            offset;
  logic [SIZE_W-1:0]     msize, ksize, nsize;
  logic [$clog2(CMD_DEPTH):0] fifo_count;
  gemm_cmd_t             new_cmd;

  // Reset asserts immediately but releases only after two clean clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  assign offset  = system_bus_addr[4:0];
  assign hit     = (system_bus_addr[31:5] == BASE_ADDR[31:5]) && (system_bus_addr[1:0] == 2'b00);
  assign wr_en   = system_bus_en && system_bus_rdwr && hit;
  assign rd_en   = system_bus_en && !system_bus_rdwr && hit && rst_n;
  assign msize   = dim_field(system_bus_wr_data, DIM_M_LSB);
  assign ksize   = dim_field(system_bus_wr_data, DIM_K_LSB);
  assign nsize   = dim_field(system_bus_wr_data, DIM_N_LSB);
  assign size_ok = (msize != '0) && (ksize != '0) && (nsize != '0);
  assign pop     = cmd_valid && cmd_ready;
  assign cmd_valid = !empty;
  assign done    = empty && !engine_busy && !cmd_valid;

  // Command assembled from the shadows already holding prior writes plus the DIM sizes.
  always_comb begin
    new_cmd             = '0;
    new_cmd.tile_a_addr = a_addr_q;
    new_cmd.tile_b_addr = b_addr_q;
    new_cmd.tile_c_addr = c_addr_q;
    new_cmd.a_stride    = a_stride_q;
    new_cmd.b_stride    = b_stride_q;
    new_cmd.first       = first_q;
    new_cmd.last        = last_q;
    new_cmd.msize       = msize;
    new_cmd.ksize       = ksize;
    new_cmd.nsize       = nsize;
  end

  // Register write decode, commit/push decision and sticky status bits.
  always_comb begin
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    c_addr_d   = c_addr_q;
    a_stride_d = a_stride_q;
    b_stride_d = b_stride_q;
    first_d    = first_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    derr_d     = derr_q;
    push       = 1'b0;
    if (wr_en) begin
      case (offset)
        REG_A_ADDR:   a_addr_d   = system_bus_wr_data[ADDR_W-1:0];
        REG_B_ADDR:   b_addr_d   = system_bus_wr_data[ADDR_W-1:0];
        REG_C_ADDR:   c_addr_d   = system_bus_wr_data[ADDR_W-1:0];
        REG_A_STRIDE: a_stride_d = system_bus_wr_data[STRIDE_W-1:0];
        REG_B_STRIDE: b_stride_d = system_bus_wr_data[STRIDE_W-1:0];
        REG_CONTROL: begin
          last_d  = system_bus_wr_data[0];
          first_d = system_bus_wr_data[1];
        end
        REG_DIM: begin
          push = !full && size_ok;
          if (full)     ovf_d  = 1'b1;
          if (!size_ok) derr_d = 1'b1;
        end
        REG_STATUS: begin
          if (system_bus_wr_data[2]) ovf_d  = 1'b0;
          if (system_bus_wr_data[3]) derr_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Shadow and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      a_stride_q <= '0;
      b_stride_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      a_stride_q <= a_stride_d;
      b_stride_q <= b_stride_d;
      first_q    <= first_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      derr_q     <= derr_d;
    end
  end

  // Combinational read mux; offset 0x00 reports full rather than the tile A shadow.
  always_comb begin
    system_bus_rd_data = '0;
    if (rd_en) begin
      case (offset)
        REG_A_ADDR:   system_bus_rd_data = {31'b0, full};
        REG_B_ADDR:   system_bus_rd_data = 32'(b_addr_q);
        REG_C_ADDR:   system_bus_rd_data = 32'(c_addr_q);
        REG_A_STRIDE: system_bus_rd_data = 32'(a_stride_q);
        REG_B_STRIDE: system_bus_rd_data = 32'(b_stride_q);
        REG_CONTROL:  system_bus_rd_data = {30'b0, first_q, last_q};
        REG_DIM:      system_bus_rd_data = {31'b0, done};
        REG_STATUS:   system_bus_rd_data = {24'b0, 4'(fifo_count), derr_q, ovf_q, empty, full};
        default:      system_bus_rd_data = '0;
      endcase
    end
  end

  gemm_cmd_fifo #(
    .T     (gemm_cmd_t),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (new_cmd),
    .pop   (pop),
    .rdata (cmd_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_gemm_cmd_regs.sv
// Directed bench for gemm_cmd_regs with a command scoreboard checked on every pop.
module tb_gemm_cmd_regs;
  import gemm_cmd_regs_pkg::*;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, rdwr = 1'b0, cmd_ready = 1'b0, engine_busy = 1'b0;
  logic [31:0] addr = '0, wr_data = '0, rd_data;
  logic        cmd_valid;
  gemm_cmd_t   cmd_data;

  int checks = 0;
  int errors = 0;

  gemm_cmd_t   exp_q[$];
  logic [31:0] m_a = '0, m_b = '0, m_c = '0, m_sa = '0, m_sb = '0;
  logic        m_first = 1'b0, m_last = 1'b0, m_ovf = 1'b0, m_derr = 1'b0;

  always #5 clk = ~clk;

  gemm_cmd_regs #(
    .BASE_ADDR (BASE),
    .ADDR_W    (32),
    .STRIDE_W  (32),
    .CMD_DEPTH (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .system_bus_en      (en),
    .system_bus_rdwr    (rdwr),
    .system_bus_addr    (addr),
    .system_bus_wr_data (wr_data),
    .system_bus_rd_data (rd_data),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_data           (cmd_data),
    .engine_busy        (engine_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input gemm_cmd_t obs, input gemm_cmd_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = exp_q.size();
    return {24'b0, 4'(n), m_derr, m_ovf, (n == 0), (n == 4)};
  endfunction

  function automatic logic [31:0] dim(input int m, input int k, input int n);
    return 32'(m) | (32'(k) << 5) | (32'(n) << 10);
  endfunction

  // One clock: scoreboard check of a pop that will happen at the coming edge, then step past it.
  task automatic tick();
    @(negedge clk);
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk_cmd("pop_data", cmd_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
    gemm_cmd_t c;
    case (off)
      5'h00: m_a  = data;
      5'h04: m_b  = data;
      5'h08: m_c  = data;
      5'h0C: m_sa = data;
      5'h10: m_sb = data;
      5'h14: begin m_last = data[0]; m_first = data[1]; end
      5'h18: begin
        c.tile_a_addr = m_a;  c.tile_b_addr = m_b;  c.tile_c_addr = m_c;
        c.a_stride    = m_sa; c.b_stride    = m_sb;
        c.first = m_first; c.last = m_last;
        c.msize = data[4:0]; c.ksize = data[9:5]; c.nsize = data[14:10];
        if (exp_q.size() >= 4) m_ovf = 1'b1;
        if (c.msize == 0 || c.ksize == 0 || c.nsize == 0) m_derr = 1'b1;
        else if (exp_q.size() < 4) exp_q.push_back(c);
      end
      5'h1C: begin
        if (data[2]) m_ovf  = 1'b0;
        if (data[3]) m_derr = 1'b0;
      end
      default: ;
    endcase
    en = 1'b1; rdwr = 1'b1; addr = BASE | {27'b0, off}; wr_data = data;
    tick();
    en = 1'b0; rdwr = 1'b0; wr_data = '0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    en = 1'b1; rdwr = 1'b0; addr = BASE | {27'b0, off};
    #1;
    chk(tag, rd_data, exp);
    en = 1'b0;
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    cmd_ready = 1'b0;
    chk("drain_valid", {31'b0, cmd_valid}, 32'd0);
  endtask

  initial begin
    gemm_cmd_t t1;

    // Reset state
    tick(); tick();
    chk("rst_valid", {31'b0, cmd_valid}, 32'd0);
    chk_cmd("rst_data", cmd_data, '0);
    read_chk("rst_rd_status", 5'h1C, 32'h0);
    rst = 1'b1;
    tick(); tick(); tick();
    chk("idle_rd", rd_data, 32'h0);
    read_chk("status_init", 5'h1C, 32'h0000_0002);
    read_chk("done_init", 5'h18, 32'h1);

    // 1: single command commit and content
    bus_write(5'h00, 32'd0);
    bus_write(5'h04, 32'd110);
    bus_write(5'h08, 32'd200);
    bus_write(5'h0C, 32'd5);
    bus_write(5'h10, 32'd4);
    bus_write(5'h14, 32'd3);
    chk("t1_pre_valid", {31'b0, cmd_valid}, 32'd0);
    read_chk("t1_rd_b", 5'h04, 32'd110);
    read_chk("t1_rd_ctrl", 5'h14, 32'd3);
    bus_write(5'h18, dim(5, 3, 4));
    chk("t1_valid", {31'b0, cmd_valid}, 32'd1);
    t1.tile_a_addr = 32'd0;  t1.tile_b_addr = 32'd110; t1.tile_c_addr = 32'd200;
    t1.a_stride = 32'd5; t1.b_stride = 32'd4; t1.first = 1'b1; t1.last = 1'b1;
    t1.msize = 5'd5; t1.ksize = 5'd3; t1.nsize = 5'd4;
    chk_cmd("t1_data", cmd_data, t1);
    drain();

    // 2: fill to full, overflow, combined overflow+dim_err, full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      bus_write(5'h00, 32'h1000 * (i + 1));
      bus_write(5'h18, dim(i + 1, 2, 3));
    end
    read_chk("t2_full", 5'h00, 32'h1);
    bus_write(5'h18, dim(7, 7, 7));
    read_chk("t2_status_ovf", 5'h1C, 32'h0000_0045);
    bus_write(5'h1C, 32'h4);
    read_chk("t2_status_clr", 5'h1C, 32'h0000_0041);
    bus_write(5'h18, dim(0, 1, 1));
    read_chk("t2_status_both", 5'h1C, 32'h0000_004D);
    bus_write(5'h1C, 32'hC);
    cmd_ready = 1'b1;
    bus_write(5'h18, dim(9, 9, 9));
    cmd_ready = 1'b0;
    read_chk("t2_full_pop", 5'h1C, 32'h0000_0034);
    chk("t2_model", exp_status(), 32'h0000_0034);
    bus_write(5'h1C, 32'h4);
    drain();

    // 3: zero size rejected
    bus_write(5'h18, dim(3, 0, 2));
    chk("t3_valid", {31'b0, cmd_valid}, 32'd0);
    read_chk("t3_status", 5'h1C, 32'h0000_000A);
    bus_write(5'h1C, 32'h8);
    read_chk("t3_status_clr", 5'h1C, 32'h0000_0002);

    // 4: push and pop in the same cycle keeps count, order preserved
    for (int i = 0; i < 3; i++) begin
      bus_write(5'h04, 32'hB000 + 32'(i));
      bus_write(5'h18, dim(1, i + 1, 2));
    end
    bus_write(5'h04, 32'hBEEF);
    cmd_ready = 1'b1;
    bus_write(5'h18, dim(4, 4, 4));
    cmd_ready = 1'b0;
    read_chk("t4_count", 5'h1C, 32'h0000_0030);
    chk("t4_model", exp_status(), 32'h0000_0030);
    drain();

    // 5: done status tracks engine_busy combinationally
    engine_busy = 1'b1;
    read_chk("t5_busy", 5'h18, 32'h0);
    engine_busy = 1'b0;
    read_chk("t5_idle", 5'h18, 32'h1);
    bus_write(5'h18, dim(2, 2, 2));
    read_chk("t5_queued", 5'h18, 32'h0);
    read_chk("t5_unaligned", 5'h19, 32'h0);
    read_chk("t5_unmapped", 5'h04, 32'hBEEF);
    drain();

    // 6: reset mid-operation discards queued commands
    bus_write(5'h18, dim(1, 1, 1));
    bus_write(5'h18, dim(2, 1, 1));
    read_chk("t6_pre", 5'h1C, 32'h0000_0020);
    rst = 1'b0;
    #1;
    chk("t6_valid", {31'b0, cmd_valid}, 32'd0);
    read_chk("t6_rd_full", 5'h00, 32'h0);
    read_chk("t6_rd_b", 5'h04, 32'h0);
    exp_q.delete();
    m_a = '0; m_b = '0; m_c = '0; m_sa = '0; m_sb = '0;
    m_first = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_derr = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("t6_post_valid", {31'b0, cmd_valid}, 32'd0);
    chk_cmd("t6_post_data", cmd_data, '0);
    read_chk("t6_post_status", 5'h1C, 32'h0000_0002);
    read_chk("t6_post_b", 5'h04, 32'h0);
    bus_write(5'h08, 32'hC0DE);
    bus_write(5'h18, dim(6, 6, 6));
    chk("t6_new_valid", {31'b0, cmd_valid}, 32'd1);
    drain();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
